// File: rtl/lightbike_arena_engine.sv
// Lightbike arena core: trail grid, player heads, tick-driven movement,
// wall/trail/head-on collision resolution, per-player scores across rounds.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   start, ack         1-cycle pulses: begin match / advance round-over & match-over
//   dir_valid, dir_in  per-player direction strobe and packed 2-bit dirs
//   rd_x, rd_y         renderer cell address; rd_owner is its registered owner
//   head_x, head_y     packed head coordinates
//   alive, score       per-player alive flags and packed scores
//   winner             last round result, 0 = draw, p+1 = player p
//   state              one-hot {MATCH_OVER,ROUND_OVER,RUN,CLEAR,IDLE}
module lightbike_arena_engine #(
   parameter int NUM_PLAYERS = 2,
   parameter int GRID_W      = 16,
   parameter int GRID_H      = 16,
   parameter int XW          = $clog2(GRID_W),
   parameter int YW          = $clog2(GRID_H),
   parameter int TICK_DIV    = 12_500_000,
   parameter int WIN_SCORE   = 5,
   parameter int SCORE_W     = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic                           ack,
   input  logic [NUM_PLAYERS-1:0]         dir_valid,
   input  logic [2*NUM_PLAYERS-1:0]       dir_in,
   input  logic [XW-1:0]                  rd_x,
   input  logic [YW-1:0]                  rd_y,
   output logic [2:0]                     rd_owner,
   output logic [XW*NUM_PLAYERS-1:0]      head_x,
   output logic [YW*NUM_PLAYERS-1:0]      head_y,
   output logic [NUM_PLAYERS-1:0]         alive,
   output logic [SCORE_W*NUM_PLAYERS-1:0] score,
   output logic [2:0]                     winner,
   output logic [4:0]                     state
);

   localparam int NP = NUM_PLAYERS;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_CLEAR = 5'b00010,
      S_RUN   = 5'b00100,
      S_ROUND = 5'b01000,
      S_MATCH = 5'b10000
   } state_t;

   state_t             r_state;
   logic [TW-1:0]      r_tcnt;
   logic [YW-1:0]      r_row;
   logic [XW-1:0]      r_hx     [NP];
   logic [YW-1:0]      r_hy     [NP];
   logic [1:0]         r_cdir   [NP];
   logic [1:0]         r_pdir   [NP];
   logic [SCORE_W-1:0] r_score  [NP];
   logic [NP-1:0]      r_alive;
   logic [2:0]         r_winner;
   logic [2:0]         r_rd_owner;
   logic [2:0]         r_grid   [GRID_H][GRID_W];

   logic [XW-1:0]      w_nx     [NP];
   logic [YW-1:0]      w_ny     [NP];
   logic [NP-1:0]      w_die;
   logic [NP-1:0]      w_alive_nx;
   logic [2:0]         w_n_alive;
   logic [2:0]         w_win;
   logic               w_match;
   logic               w_tick;
   logic               w_enter_clear;
   logic               w_rd_wall;

   function automatic logic [XW-1:0] f_sx(int p);
      return XW'((p + 1) * GRID_W / (NP + 1));
   endfunction

   function automatic logic [1:0] f_sdir(int p);
      return (p % 2 == 0) ? 2'd1 : 2'd3;
   endfunction

   assign w_tick = (r_state == S_RUN) && (r_tcnt == TW'(TICK_DIV - 1));
   assign w_enter_clear = ((r_state == S_IDLE) && start) ||
                          ((r_state == S_ROUND) && ack && !w_match);

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         w_nx[p] = r_hx[p];
         w_ny[p] = r_hy[p];
         case (r_pdir[p])
            2'd0:    w_ny[p] = r_hy[p] - YW'(1);
            2'd1:    w_nx[p] = r_hx[p] + XW'(1);
            2'd2:    w_ny[p] = r_hy[p] + YW'(1);
            default: w_nx[p] = r_hx[p] - XW'(1);
         endcase
      end
   end

   // Current heads are not yet in the grid (written at this same tick),
   // so they are compared explicitly alongside the grid lookup.
   always_comb begin
      w_die = '0;
      for (int p = 0; p < NP; p++) begin
         if (r_alive[p]) begin
            if (w_nx[p] == '0 || w_nx[p] == XW'(GRID_W - 1) ||
                w_ny[p] == '0 || w_ny[p] == YW'(GRID_H - 1))
               w_die[p] = 1'b1;
            else if (r_grid[w_ny[p]][w_nx[p]] != 3'd0)
               w_die[p] = 1'b1;
            for (int q = 0; q < NP; q++) begin
               if (r_alive[q] && w_nx[p] == r_hx[q] && w_ny[p] == r_hy[q])
                  w_die[p] = 1'b1;
               if (q != p && r_alive[q] &&
                   w_nx[p] == w_nx[q] && w_ny[p] == w_ny[q])
                  w_die[p] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_alive_nx = r_alive & ~w_die;
      w_n_alive  = 3'd0;
      w_win      = 3'd0;
      w_match    = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (w_alive_nx[p]) begin
            w_n_alive = w_n_alive + 3'd1;
            w_win     = 3'(p + 1);
         end
         if (r_score[p] == SCORE_W'(WIN_SCORE))
            w_match = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_tcnt   <= '0;
         r_row    <= '0;
         r_alive  <= '0;
         r_winner <= 3'd0;
         for (int p = 0; p < NP; p++) begin
            r_hx[p]    <= f_sx(p);
            r_hy[p]    <= YW'(GRID_H / 2);
            r_cdir[p]  <= f_sdir(p);
            r_pdir[p]  <= f_sdir(p);
            r_score[p] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start)
                  r_state <= S_CLEAR;
            end
            S_CLEAR: begin
               r_row <= r_row + YW'(1);
               if (r_row == YW'(GRID_H - 1)) begin
                  r_state <= S_RUN;
                  r_tcnt  <= '0;
               end
            end
            S_RUN: begin
               r_tcnt <= w_tick ? '0 : r_tcnt + TW'(1);
               for (int p = 0; p < NP; p++) begin
                  if (w_tick)
                     r_cdir[p] <= r_pdir[p];
                  // Reversal is judged against the committed heading.
                  if (dir_valid[p] &&
                      dir_in[2*p +: 2] != (r_cdir[p] ^ 2'd2))
                     r_pdir[p] <= dir_in[2*p +: 2];
               end
               if (w_tick) begin
                  r_alive <= w_alive_nx;
                  for (int p = 0; p < NP; p++) begin
                     if (w_alive_nx[p]) begin
                        r_hx[p] <= w_nx[p];
                        r_hy[p] <= w_ny[p];
                     end
                  end
                  if (w_n_alive <= 3'd1) begin
                     r_state  <= S_ROUND;
                     r_winner <= w_win;
                     for (int p = 0; p < NP; p++) begin
                        if (w_n_alive == 3'd1 && w_alive_nx[p] &&
                            r_score[p] != '1)
                           r_score[p] <= r_score[p] + SCORE_W'(1);
                     end
                  end
               end
            end
            S_ROUND: begin
               if (ack)
                  r_state <= w_match ? S_MATCH : S_CLEAR;
            end
            S_MATCH: begin
               if (ack) begin
                  r_state <= S_IDLE;
                  for (int p = 0; p < NP; p++)
                     r_score[p] <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_enter_clear) begin
            r_row    <= '0;
            r_alive  <= '1;
            r_winner <= 3'd0;
            for (int p = 0; p < NP; p++) begin
               r_hx[p]   <= f_sx(p);
               r_hy[p]   <= YW'(GRID_H / 2);
               r_cdir[p] <= f_sdir(p);
               r_pdir[p] <= f_sdir(p);
            end
         end
      end
   end

   // Grid is rebuilt by CLEAR, so it needs no reset.
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         for (int x = 0; x < GRID_W; x++)
            r_grid[r_row][x] <= 3'd0;
      end else if (w_tick) begin
         for (int p = 0; p < NP; p++) begin
            if (r_alive[p])
               r_grid[r_hy[p]][r_hx[p]] <= 3'(p + 1);
         end
      end
   end

   // Border and out-of-arena addresses read as wall.
   assign w_rd_wall = (rd_x == '0) || (rd_x >= XW'(GRID_W - 1)) ||
                      (rd_y == '0) || (rd_y >= YW'(GRID_H - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_rd_owner <= 3'd0;
      else
         r_rd_owner <= w_rd_wall ? 3'd7 : r_grid[rd_y][rd_x];
   end

   always_comb begin
      head_x = '0;
      head_y = '0;
      score  = '0;
      for (int p = 0; p < NP; p++) begin
         head_x[p*XW +: XW]           = r_hx[p];
         head_y[p*YW +: YW]           = r_hy[p];
         score[p*SCORE_W +: SCORE_W]  = r_score[p];
      end
   end

   assign rd_owner = r_rd_owner;
   assign alive    = r_alive;
   assign winner   = r_winner;
   assign state    = r_state;

endmodule

// File: tb/tb_lightbike_arena_engine.sv
// Scoreboard bench for lightbike_arena_engine: directed game scenarios
// push expected outputs; a negedge monitor pops and compares them.
module tb_lightbike_arena_engine;

   localparam int NP = 2;
   localparam int XW = 4;
   localparam int YW = 4;
   localparam int SW = 4;

   localparam int K_ST  = 0;
   localparam int K_AL  = 1;
   localparam int K_SC  = 2;
   localparam int K_WN  = 3;
   localparam int K_HX  = 4;
   localparam int K_HY  = 5;
   localparam int K_OWN = 6;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            start;
   logic            ack;
   logic [NP-1:0]   dir_valid;
   logic [2*NP-1:0] dir_in;
   logic [XW-1:0]   rd_x;
   logic [YW-1:0]   rd_y;
   logic [2:0]      rd_owner;
   logic [XW*NP-1:0] head_x;
   logic [YW*NP-1:0] head_y;
   logic [NP-1:0]   alive;
   logic [SW*NP-1:0] score;
   logic [2:0]      winner;
   logic [4:0]      state;

   lightbike_arena_engine #(
      .NUM_PLAYERS(NP), .GRID_W(16), .GRID_H(16),
      .TICK_DIV(4), .WIN_SCORE(2), .SCORE_W(SW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ack(ack),
      .dir_valid(dir_valid), .dir_in(dir_in),
      .rd_x(rd_x), .rd_y(rd_y), .rd_owner(rd_owner),
      .head_x(head_x), .head_y(head_y), .alive(alive),
      .score(score), .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] f_act(int s);
      case (s)
         K_ST:    return 32'(state);
         K_AL:    return 32'(alive);
         K_SC:    return 32'(score);
         K_WN:    return 32'(winner);
         K_HX:    return 32'(head_x);
         K_HY:    return 32'(head_y);
         K_OWN:   return 32'(rd_owner);
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   always @(negedge clk) begin : mon
      exp_t        e;
      logic [31:0] a;
      while (q.size() > 0) begin
         e = q.pop_front();
         a = f_act(e.sig);
         checks++;
         if (a !== e.val) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", e.name, a, e.val);
         end
      end
   end

   task automatic expect_v(string n, int s, logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sig  = s;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      step(1);
      ack = 1'b0;
   endtask

   task automatic drive_dir(logic [NP-1:0] v, logic [2*NP-1:0] d);
      dir_valid = v;
      dir_in    = d;
      step(1);
      dir_valid = '0;
   endtask

   // Called right after entering CLEAR: p0 goes UP, p1 DOWN; p1 hits
   // the bottom wall at tick 7 and p0 takes the round.
   task automatic run_s3(string tag, logic [31:0] exp_sc);
      step(16);
      expect_v({tag, "_run"}, K_ST, 5'b00100);
      drive_dir(2'b11, 4'b1000);
      step(23);
      expect_v({tag, "_t6_hx"}, K_HX, 8'hA5);
      expect_v({tag, "_t6_hy"}, K_HY, 8'hE2);
      expect_v({tag, "_t6_alive"}, K_AL, 2'b11);
      step(4);
      expect_v({tag, "_t7_state"}, K_ST, 5'b01000);
      expect_v({tag, "_t7_alive"}, K_AL, 2'b01);
      expect_v({tag, "_t7_winner"}, K_WN, 3'd1);
      expect_v({tag, "_t7_hy"}, K_HY, 8'hE1);
      expect_v({tag, "_t7_score"}, K_SC, exp_sc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      ack       = 1'b0;
      dir_valid = '0;
      dir_in    = '0;
      rd_x      = '0;
      rd_y      = '0;
      step(3);
      reset_n = 1'b1;
      expect_v("rst_state", K_ST, 5'b00001);
      expect_v("rst_alive", K_AL, 2'b00);
      expect_v("rst_score", K_SC, 8'h00);
      expect_v("rst_winner", K_WN, 3'd0);
      expect_v("rst_owner", K_OWN, 3'd0);
      expect_v("rst_hx", K_HX, 8'hA5);
      expect_v("rst_hy", K_HY, 8'h88);
      step(2);

      // Straight run into a swap collision, plus read-port probes.
      pulse_start();
      expect_v("s2_clear", K_ST, 5'b00010);
      expect_v("s2_alive", K_AL, 2'b11);
      step(15);
      expect_v("s2_clear15", K_ST, 5'b00010);
      step(1);
      expect_v("s2_run", K_ST, 5'b00100);
      step(3);
      expect_v("s2_pre_t1", K_HX, 8'hA5);
      step(1);
      expect_v("s2_t1_hx", K_HX, 8'h96);
      expect_v("s2_t1_hy", K_HY, 8'h88);
      rd_x = 4'd5;  rd_y = 4'd8;
      step(1);
      expect_v("s6_trail_p0", K_OWN, 3'd1);
      rd_x = 4'd0;  rd_y = 4'd3;
      step(1);
      expect_v("s6_wall", K_OWN, 3'd7);
      rd_x = 4'd6;  rd_y = 4'd8;
      step(1);
      expect_v("s6_head_empty", K_OWN, 3'd0);
      rd_x = 4'd10; rd_y = 4'd8;
      step(1);
      expect_v("s6_trail_p1", K_OWN, 3'd2);
      expect_v("s2_t2_hx", K_HX, 8'h87);
      step(4);
      expect_v("s2_t3_alive", K_AL, 2'b00);
      expect_v("s2_t3_state", K_ST, 5'b01000);
      expect_v("s2_t3_winner", K_WN, 3'd0);
      expect_v("s2_t3_score", K_SC, 8'h00);
      expect_v("s2_t3_hx", K_HX, 8'h87);

      // Steering: reversal, last-wins, tick-cycle request, trail hit.
      pulse_ack();
      expect_v("s4_clear", K_ST, 5'b00010);
      expect_v("s4_alive", K_AL, 2'b11);
      expect_v("s4_hx", K_HX, 8'hA5);
      step(16);
      expect_v("s4_run", K_ST, 5'b00100);
      drive_dir(2'b01, 4'b0011);
      drive_dir(2'b01, 4'b0000);
      drive_dir(2'b01, 4'b0010);
      step(1);
      expect_v("s4_t1_hx", K_HX, 8'h95);
      expect_v("s4_t1_hy", K_HY, 8'h89);
      step(1);
      drive_dir(2'b01, 4'b0000);
      step(2);
      expect_v("s4_t2_hx", K_HX, 8'h85);
      expect_v("s4_t2_hy", K_HY, 8'h8A);
      step(3);
      drive_dir(2'b01, 4'b0001);
      expect_v("s4_t3_hx", K_HX, 8'h75);
      expect_v("s4_t3_hy", K_HY, 8'h8B);
      step(4);
      expect_v("s4_t4_hx", K_HX, 8'h66);
      step(4);
      expect_v("s4_t5_alive", K_AL, 2'b01);
      expect_v("s4_t5_state", K_ST, 5'b01000);
      expect_v("s4_t5_winner", K_WN, 3'd1);
      expect_v("s4_t5_score", K_SC, 8'h01);
      expect_v("s4_t5_hx", K_HX, 8'h67);

      // Async reset in the middle of a round.
      pulse_ack();
      expect_v("s1_clear", K_ST, 5'b00010);
      step(20);
      expect_v("s1_t1_hx", K_HX, 8'h96);
      step(1);
      reset_n = 1'b0;
      #1;
      expect_v("s1_state", K_ST, 5'b00001);
      expect_v("s1_score", K_SC, 8'h00);
      expect_v("s1_alive", K_AL, 2'b00);
      expect_v("s1_winner", K_WN, 3'd0);
      expect_v("s1_hx", K_HX, 8'hA5);
      step(2);
      reset_n = 1'b1;
      step(1);

      // Two won rounds reach WIN_SCORE and end the match.
      pulse_start();
      expect_v("s5_clear", K_ST, 5'b00010);
      run_s3("s5a", 8'h01);
      pulse_ack();
      expect_v("s5_clear2", K_ST, 5'b00010);
      run_s3("s5b", 8'h02);
      pulse_ack();
      expect_v("s5_match", K_ST, 5'b10000);
      expect_v("s5_match_sc", K_SC, 8'h02);
      pulse_start();
      expect_v("s5_start_ign", K_ST, 5'b10000);
      pulse_ack();
      expect_v("s5_idle", K_ST, 5'b00001);
      expect_v("s5_idle_sc", K_SC, 8'h00);

      step(2);
      if (q.size() != 0) begin
         $display("FAIL leftover: got %0d unchecked, want 0", q.size());
         errors += q.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
